// File: rtl/strm_hub_pkg.sv
// Shared constants for the stream bridge hub: register map and statistics counter width.
package strm_hub_pkg;

  localparam int          CNT_W        = 32;
  localparam logic [19:0] CNT_H2U_BASE = 20'h00100;
  localparam logic [19:0] CNT_U2H_BASE = 20'h00140;
  localparam logic [19:0] STAT_CLR     = 20'h00180;
  localparam logic [19:0] WIN_MASK     = 20'hFFF00;

  // The register window is the 256-byte page starting at CNT_H2U_BASE.
  function automatic logic in_window(input logic [19:0] addr);
    return (addr & WIN_MASK) == CNT_H2U_BASE;
  endfunction

endpackage

// File: rtl/strm_fifo.sv
// Synchronous first-word-fall-through FIFO; one push and one pop per cycle.
module strm_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  do_push, do_pop;

  assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  // Depth is a power of two, so plain pointer overflow gives the wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/strm_bridge_hub.sv
// Stream bridge between switch ports and user logic: per-channel FIFOs both ways, optional
// half-swap, and word-count statistics enabled by defining STRM_HUB_STATS_EN.
module strm_bridge_hub
  import strm_hub_pkg::*;
#(
  parameter int NUM_STRM    = 4,
  parameter int DATA_WIDTH  = 64,
  parameter int FIFO_DEPTH  = 16,
  parameter int SWAP_HALVES = 1
) (
  input  logic                           i_pcie_clk,
  input  logic                           i_rst,
  input  logic [NUM_STRM-1:0]            i_h2u_valid,
  output logic [NUM_STRM-1:0]            o_h2u_ack,
  input  logic [NUM_STRM*DATA_WIDTH-1:0] i_h2u_data,
  output logic [NUM_STRM-1:0]            o_h2u_usr_valid,
  input  logic [NUM_STRM-1:0]            i_h2u_usr_ack,
  output logic [NUM_STRM*DATA_WIDTH-1:0] o_h2u_usr_data,
  input  logic [NUM_STRM-1:0]            i_u2h_usr_valid,
  output logic [NUM_STRM-1:0]            o_u2h_usr_ack,
  input  logic [NUM_STRM*DATA_WIDTH-1:0] i_u2h_usr_data,
  output logic [NUM_STRM-1:0]            o_u2h_valid,
  input  logic [NUM_STRM-1:0]            i_u2h_ack,
  output logic [NUM_STRM*DATA_WIDTH-1:0] o_u2h_data,
  input  logic [19:0]                    i_user_addr,
  input  logic [31:0]                    i_user_data,
  input  logic                           i_user_wr_req,
  input  logic                           i_user_rd_req,
  output logic [31:0]                    o_user_data,
  output logic                           o_user_rd_ack
);

  localparam int DW = DATA_WIDTH;
  localparam int HW = DATA_WIDTH / 2;

  logic [NUM_STRM-1:0] h2u_push, h2u_pop, h2u_full, h2u_empty;
  logic [NUM_STRM-1:0] u2h_push, u2h_pop, u2h_full, u2h_empty;

  generate
    for (genvar gi = 0; gi < NUM_STRM; gi++) begin : g_ch
      logic [DW-1:0] h2u_din, u2h_din;

      if (SWAP_HALVES != 0) begin : g_swap
        assign h2u_din = {i_h2u_data[gi*DW +: HW], i_h2u_data[gi*DW+HW +: HW]};
        assign u2h_din = {i_u2h_usr_data[gi*DW +: HW], i_u2h_usr_data[gi*DW+HW +: HW]};
      end else begin : g_pass
        assign h2u_din = i_h2u_data[gi*DW +: DW];
        assign u2h_din = i_u2h_usr_data[gi*DW +: DW];
      end

      // Handshakes are forced low during reset so neither side sees a stale ack/valid.
      assign o_h2u_ack[gi]       = !h2u_full[gi] && !i_rst;
      assign h2u_push[gi]        = i_h2u_valid[gi] && o_h2u_ack[gi];
      assign o_h2u_usr_valid[gi] = !h2u_empty[gi] && !i_rst;
      assign h2u_pop[gi]         = o_h2u_usr_valid[gi] && i_h2u_usr_ack[gi];

      assign o_u2h_usr_ack[gi]   = !u2h_full[gi] && !i_rst;
      assign u2h_push[gi]        = i_u2h_usr_valid[gi] && o_u2h_usr_ack[gi];
      assign o_u2h_valid[gi]     = !u2h_empty[gi] && !i_rst;
      assign u2h_pop[gi]         = o_u2h_valid[gi] && i_u2h_ack[gi];

      strm_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(FIFO_DEPTH)) u_h2u_fifo (
        .clk(i_pcie_clk), .srst(i_rst), .push(h2u_push[gi]), .din(h2u_din),
        .pop(h2u_pop[gi]), .dout(o_h2u_usr_data[gi*DW +: DW]),
        .full(h2u_full[gi]), .empty(h2u_empty[gi])
      );

      strm_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(FIFO_DEPTH)) u_u2h_fifo (
        .clk(i_pcie_clk), .srst(i_rst), .push(u2h_push[gi]), .din(u2h_din),
        .pop(u2h_pop[gi]), .dout(o_u2h_data[gi*DW +: DW]),
        .full(u2h_full[gi]), .empty(u2h_empty[gi])
      );
    end
  endgenerate

  logic        rd_ack_q, rd_ack_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [31:0] reg_val;

`ifdef STRM_HUB_STATS_EN
  logic [CNT_W-1:0] h2u_cnt_q [NUM_STRM];
  logic [CNT_W-1:0] h2u_cnt_d [NUM_STRM];
  logic [CNT_W-1:0] u2h_cnt_q [NUM_STRM];
  logic [CNT_W-1:0] u2h_cnt_d [NUM_STRM];
  logic             clr;
  logic [31:0]      unused_wdata;

  assign clr          = i_user_wr_req && (i_user_addr == STAT_CLR);
  assign unused_wdata = i_user_data;

  // Clear has priority over a push landing in the same cycle.
  always_comb begin
    for (int c = 0; c < NUM_STRM; c++) begin
      h2u_cnt_d[c] = h2u_cnt_q[c];
      u2h_cnt_d[c] = u2h_cnt_q[c];
      if (clr) begin
        h2u_cnt_d[c] = '0;
        u2h_cnt_d[c] = '0;
      end else begin
        if (h2u_push[c]) h2u_cnt_d[c] = h2u_cnt_q[c] + 1'b1;
        if (u2h_push[c]) u2h_cnt_d[c] = u2h_cnt_q[c] + 1'b1;
      end
    end
  end

  always_ff @(posedge i_pcie_clk) begin
    for (int c = 0; c < NUM_STRM; c++) begin
      if (i_rst) begin
        h2u_cnt_q[c] <= '0;
        u2h_cnt_q[c] <= '0;
      end else begin
        h2u_cnt_q[c] <= h2u_cnt_d[c];
        u2h_cnt_q[c] <= u2h_cnt_d[c];
      end
    end
  end

  always_comb begin
    reg_val = '0;
    if (i_user_addr[1:0] == 2'b00) begin
      if (i_user_addr[19:6] == CNT_H2U_BASE[19:6]) begin
        for (int c = 0; c < NUM_STRM; c++)
          if (i_user_addr[5:2] == 4'(c)) reg_val = h2u_cnt_q[c];
      end else if (i_user_addr[19:6] == CNT_U2H_BASE[19:6]) begin
        for (int c = 0; c < NUM_STRM; c++)
          if (i_user_addr[5:2] == 4'(c)) reg_val = u2h_cnt_q[c];
      end else if (i_user_addr == STAT_CLR) begin
        for (int c = 0; c < NUM_STRM; c++) begin
          reg_val[c]     = !h2u_empty[c];
          reg_val[8 + c] = !u2h_empty[c];
        end
      end
    end
  end
`else
  logic unused_regs;

  // Without statistics the window still answers reads so the host never stalls.
  assign unused_regs = ^{i_user_data, i_user_wr_req, h2u_push, u2h_push, h2u_empty, u2h_empty};

  always_comb begin
    reg_val = '0;
  end
`endif

  always_comb begin
    rd_ack_d  = i_user_rd_req && in_window(i_user_addr);
    rd_data_d = rd_ack_d ? reg_val : '0;
  end

  always_ff @(posedge i_pcie_clk) begin
    if (i_rst) begin
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_ack_q  <= rd_ack_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign o_user_rd_ack = rd_ack_q;
  assign o_user_data   = rd_data_q;

endmodule

// File: tb/tb_strm_bridge_hub.sv
// Scoreboard bench for strm_bridge_hub (NUM_STRM=4, DATA_WIDTH=64, FIFO_DEPTH=16, swap on).
module tb_strm_bridge_hub;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int D  = 16;
`ifdef STRM_HUB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            i_rst;
  logic [N-1:0]    i_h2u_valid, o_h2u_ack, o_h2u_usr_valid, i_h2u_usr_ack;
  logic [N-1:0]    i_u2h_usr_valid, o_u2h_usr_ack, o_u2h_valid, i_u2h_ack;
  logic [N*DW-1:0] i_h2u_data, o_h2u_usr_data, i_u2h_usr_data, o_u2h_data;
  logic [19:0]     i_user_addr;
  logic [31:0]     i_user_data, o_user_data;
  logic            i_user_wr_req, i_user_rd_req, o_user_rd_ack;

  strm_bridge_hub #(.NUM_STRM(N), .DATA_WIDTH(DW), .FIFO_DEPTH(D), .SWAP_HALVES(1)) dut (
    .i_pcie_clk(clk), .i_rst(i_rst),
    .i_h2u_valid(i_h2u_valid), .o_h2u_ack(o_h2u_ack), .i_h2u_data(i_h2u_data),
    .o_h2u_usr_valid(o_h2u_usr_valid), .i_h2u_usr_ack(i_h2u_usr_ack), .o_h2u_usr_data(o_h2u_usr_data),
    .i_u2h_usr_valid(i_u2h_usr_valid), .o_u2h_usr_ack(o_u2h_usr_ack), .i_u2h_usr_data(i_u2h_usr_data),
    .o_u2h_valid(o_u2h_valid), .i_u2h_ack(i_u2h_ack), .o_u2h_data(o_u2h_data),
    .i_user_addr(i_user_addr), .i_user_data(i_user_data), .i_user_wr_req(i_user_wr_req),
    .i_user_rd_req(i_user_rd_req), .o_user_data(o_user_data), .o_user_rd_ack(o_user_rd_ack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_h2u [N][$];
  logic [63:0] exp_u2h [N][$];
  logic [31:0] exp_rd [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic logic [63:0] swap(input logic [63:0] x);
    return {x[31:0], x[63:32]};
  endfunction

  function automatic logic [31:0] cnt(input int v);
    return STATS ? 32'(v) : 32'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [19:0] a, input logic [31:0] e, input bit win);
    i_user_addr   = a;
    i_user_rd_req = 1'b1;
    if (win) exp_rd.push_back(e);
    step();
    i_user_rd_req = 1'b0;
    check($sformatf("rd_ack_latency_%h", a), 64'(o_user_rd_ack), 64'(win));
    step();
    check($sformatf("rd_ack_pulse_%h", a), 64'(o_user_rd_ack), 64'd0);
  endtask

  // Monitor: compares every completed output transfer against the scoreboard queues.
  always @(negedge clk) begin
    logic [63:0] e;
    for (int c = 0; c < N; c++) begin
      if (o_h2u_usr_valid[c] && i_h2u_usr_ack[c]) begin
        if (exp_h2u[c].size() == 0) begin
          total++; bad++;
          $display("FAIL h2u%0d_unexpected: got %h want none", c, o_h2u_usr_data[c*DW +: DW]);
        end else begin
          e = exp_h2u[c].pop_front();
          $display("h2u ch%0d word %h", c, o_h2u_usr_data[c*DW +: DW]);
          check($sformatf("h2u%0d_data", c), o_h2u_usr_data[c*DW +: DW], e);
        end
      end
      if (o_u2h_valid[c] && i_u2h_ack[c]) begin
        if (exp_u2h[c].size() == 0) begin
          total++; bad++;
          $display("FAIL u2h%0d_unexpected: got %h want none", c, o_u2h_data[c*DW +: DW]);
        end else begin
          e = exp_u2h[c].pop_front();
          $display("u2h ch%0d word %h", c, o_u2h_data[c*DW +: DW]);
          check($sformatf("u2h%0d_data", c), o_u2h_data[c*DW +: DW], e);
        end
      end
    end
    if (o_user_rd_ack) begin
      if (exp_rd.size() == 0) begin
        total++; bad++;
        $display("FAIL rd_unexpected: got %h want no ack", o_user_data);
      end else begin
        e = 64'(exp_rd.pop_front());
        $display("reg read data %h", o_user_data);
        check("rd_data", 64'(o_user_data), e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w;
    bit gap;
    i_rst = 1'b1;
    i_h2u_valid = '0; i_h2u_usr_ack = '0; i_u2h_usr_valid = '0; i_u2h_ack = '0;
    i_h2u_data = '0; i_u2h_usr_data = '0;
    i_user_addr = '0; i_user_data = '0; i_user_wr_req = 1'b0; i_user_rd_req = 1'b0;
    repeat (3) step();
    check("rst_h2u_ack", 64'(o_h2u_ack), 64'd0);
    check("rst_u2h_usr_ack", 64'(o_u2h_usr_ack), 64'd0);
    check("rst_valids", 64'({o_h2u_usr_valid, o_u2h_valid}), 64'd0);
    check("rst_rd", 64'({o_user_rd_ack, o_user_data}), 64'd0);
    i_rst = 1'b0;
    i_h2u_usr_ack = '1;
    i_u2h_ack = '1;
    step();
    check("post_rst_acks", 64'({o_h2u_ack, o_u2h_usr_ack}), 64'hFF);

    // Single word on h2u ch2, swapped, presented one cycle after the push.
    i_h2u_usr_ack = 4'b1011;
    i_h2u_valid[2] = 1'b1;
    i_h2u_data[2*DW +: DW] = 64'h1111_2222_3333_4444;
    step();
    i_h2u_valid[2] = 1'b0;
    check("ch2_valid_only", 64'(o_h2u_usr_valid), 64'h4);
    exp_h2u[2].push_back(64'h3333_4444_1111_2222);
    i_h2u_usr_ack = '1;
    step();
    check("ch2_drained", 64'(o_h2u_usr_valid), 64'h0);

    // Fill h2u ch0 to full; the 17th word waits on the source side.
    i_h2u_usr_ack[0] = 1'b0;
    for (int k = 0; k < 17; k++) begin
      w = {32'hA000_0000 + 32'(k), 32'hB000_0000 + 32'(k)};
      i_h2u_valid[0] = 1'b1;
      i_h2u_data[0 +: DW] = w;
      exp_h2u[0].push_back(swap(w));
      if (k < 16) step();
    end
    check("full_ack_low", 64'(o_h2u_ack[0]), 64'd0);
    repeat (3) begin
      step();
      check("full_ack_held", 64'(o_h2u_ack[0]), 64'd0);
    end
    check("full_valid", 64'(o_h2u_usr_valid[0]), 64'd1);
    i_h2u_usr_ack[0] = 1'b1;
    step();
    check("ack_after_pop", 64'(o_h2u_ack[0]), 64'd1);
    step();
    i_h2u_valid[0] = 1'b0;
    repeat (20) step();

    // Sustained push and pop on u2h ch3.
    gap = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      w = {32'(k), ~32'(k)};
      i_u2h_usr_valid[3] = 1'b1;
      i_u2h_usr_data[3*DW +: DW] = w;
      exp_u2h[3].push_back(swap(w));
      if (o_u2h_usr_ack[3] !== 1'b1) gap = 1'b1;
      if (k > 0 && o_u2h_valid[3] !== 1'b1) gap = 1'b1;
      step();
    end
    i_u2h_usr_valid[3] = 1'b0;
    check("u2h3_no_gap", 64'(gap), 64'd0);
    repeat (3) step();
    rd(20'h14C, cnt(1000), 1'b1);
    rd(20'h100, cnt(17), 1'b1);
    rd(20'h108, cnt(1), 1'b1);
    rd(20'h144, 32'd0, 1'b1);

    // Clear in the same cycle as a push on h2u ch1.
    w = 64'hDEAD_BEEF_0123_4567;
    i_h2u_valid[1] = 1'b1;
    i_h2u_data[1*DW +: DW] = w;
    exp_h2u[1].push_back(swap(w));
    i_user_addr = 20'h180;
    i_user_wr_req = 1'b1;
    step();
    i_h2u_valid[1] = 1'b0;
    i_user_wr_req = 1'b0;
    rd(20'h104, 32'd0, 1'b1);
    rd(20'h14C, 32'd0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      w = 64'h5555_0000_0000_0000 + 64'(k);
      i_h2u_valid[1] = 1'b1;
      i_h2u_data[1*DW +: DW] = w;
      exp_h2u[1].push_back(swap(w));
      step();
    end
    i_h2u_valid[1] = 1'b0;
    rd(20'h104, cnt(2), 1'b1);

    // Buffer words, read status, then reset mid-transfer.
    i_h2u_usr_ack[1] = 1'b0;
    i_u2h_ack[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      i_h2u_valid[1] = 1'b1;
      i_h2u_data[1*DW +: DW] = 64'h7777_0000_0000_0000 + 64'(k);
      i_u2h_usr_valid[0] = (k == 0);
      i_u2h_usr_data[0 +: DW] = 64'h8888_0000_0000_0001;
      step();
    end
    i_h2u_valid[1] = 1'b0;
    i_u2h_usr_valid[0] = 1'b0;
    rd(20'h180, STATS ? 32'h0000_0102 : 32'd0, 1'b1);
    i_rst = 1'b1;
    #1;
    check("rst_assert_valids", 64'({o_h2u_usr_valid, o_u2h_valid}), 64'd0);
    check("rst_assert_acks", 64'({o_h2u_ack, o_u2h_usr_ack}), 64'd0);
    step();
    check("rst_cycle_valids", 64'({o_h2u_usr_valid, o_u2h_valid}), 64'd0);
    check("rst_cycle_acks", 64'({o_h2u_ack, o_u2h_usr_ack}), 64'd0);
    step();
    i_rst = 1'b0;
    i_h2u_usr_ack = '1;
    i_u2h_ack = '1;
    repeat (8) step();
    rd(20'h180, 32'd0, 1'b1);
    rd(20'h104, 32'd0, 1'b1);

    // Window boundaries and unmapped offsets.
    rd(20'h110, 32'd0, 1'b1);
    rd(20'h1F0, 32'd0, 1'b1);
    rd(20'h200, 32'd0, 1'b0);
    rd(20'h0FC, 32'd0, 1'b0);

    repeat (4) step();
    for (int c = 0; c < N; c++) begin
      check($sformatf("h2u%0d_left", c), 64'(exp_h2u[c].size()), 64'd0);
      check($sformatf("u2h%0d_left", c), 64'(exp_u2h[c].size()), 64'd0);
    end
    check("rd_left", 64'(exp_rd.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
